pattern_scroller: RTL and testbench
===================================

# pattern_scroller

Upstream feeder for the four-digit display multiplexer. Selects one of four built-in 8-character messages and slides a 4-character window across it, one position per scroll tick, with wrap-around. Each window character is emitted as an active-low 7-segment pattern on digit0..digit3, which wire directly to the multiplexer's digit inputs. Supports direction control, pause, and single-step while paused.

## Interface
- TICK_DIV, 50_000_000: clock cycles per scroll step (2 steps/s at 100 MHz); legal range ≥ 2
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- sel  in  2  message select
- dir  in  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements)
- pause  in  1  1 = hold current position
- step  in  1  button level; each rising edge advances one position, only while pause=1
- digit3  out  8  leftmost character pattern, active-low {dp,g,f,e,d,c,b,a}
- digit2  out  8  second character from left
- digit1  out  8  third character from left
- digit0  out  8  rightmost character
- pos  out  3  current window start index into message
- wrap  out  1  one-cycle pulse when pos wraps (7→0 or 0→7)

## Operation
- Messages are 8 characters, indices 0..7:
  - sel=0: "01234567"
  - sel=1: "89AbCdEF"
  - sel=2: "dEAdbEEF"
  - sel=3: "CAFE" + 4 blanks
- Glyph codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, blank=FF. dp is always off (bit7=1).
- Window mapping, indices mod 8: digit3=msg[pos], digit2=msg[pos+1], digit1=msg[pos+2], digit0=msg[pos+3].
- Tick counter runs 0..TICK_DIV-1 and wraps. The tick fires in the cycle the counter equals TICK_DIV-1. The counter keeps running while paused.
- Advance events:
  - tick with pause=0
  - step rising edge with pause=1, detected against a registered copy of step
  - Step edges while pause=0 are ignored. Ticks while pause=1 are ignored.
- On advance: pos ← pos+1 (dir=0) or pos−1 (dir=1), modulo 8. wrap=1 for that cycle if the move crosses 7→0 or 0→7.
- sel change is detected against a registered copy of sel. In the cycle it is detected: pos←0, tick counter←0, wrap=0, and any coincident advance is discarded.
- Priority, highest first: rst, sel change, advance.
- dir may change at any time; the new value applies from the next advance.

## Timing
- Reset values:
  - digit0..digit3 = 8'hFF
  - pos = 0, wrap = 0, tick counter = 0
  - step and sel registered copies load the current inputs, so no false edge or sel change fires after reset
- First clock after rst deasserts: digits show window pos=0 of the current sel. For sel=0: digit3..digit0 = C0, F9, A4, B0.
- digits, pos and wrap are all registered and update on the same clock edge. digits always correspond to the pos value visible in that cycle.
- Advance latency:
  - tick in cycle N → new pos, digits and wrap visible in cycle N+1
  - step edge: step goes high in cycle N, sampled edge at edge N+1, new pos visible in cycle N+2
- First tick after reset or sel change occurs TICK_DIV cycles later.
- rst asserted mid-operation: all outputs return to reset values on the next edge, regardless of other inputs.

## Test plan
- TICK_DIV=4, sel=0, dir=0, pause=0, release reset → digits C0,F9,A4,B0 with pos=0; after 4 cycles pos=1 and digits F9,A4,B0,99; after 8 ticks pos=0 again, with wrap high for exactly one cycle on the 7→0 step.
- dir=1 from pos=0 → next tick gives pos=7, wrap=1, digits F8,C0,F9,A4 (sel=0).
- sel=3, pos=2 window → digits 8E,86,FF,FF. Change sel to 1 in the same cycle as a tick → pos=0 (tick discarded), digits 80,90,88,83, next tick 4 cycles later.
- pause=1 for 20 cycles → pos unchanged. Pulse step high for 3 cycles → pos advances exactly once, 2 cycles after step rises. Step pulse with pause=0 → no extra advance.
- Assert rst at pos=5 with step edge and tick in the same cycle → next cycle digits=FF×4, pos=0, wrap=0.
- Hold step high through reset release → no spurious advance after reset.

Source files
------------

// File: rtl/pattern_scroller.sv
// Scrolling 4-character window over one of four fixed 8-character messages,
// emitted as active-low 7-segment patterns for the display multiplexer.
module pattern_scroller #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       dir,
    input  logic       pause,
    input  logic       step,
    output logic [7:0] digit3,
    output logic [7:0] digit2,
    output logic [7:0] digit1,
    output logic [7:0] digit0,
    output logic [2:0] pos,
    output logic       wrap
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]        BLANK    = 5'h10;

    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       pos_nx;
    logic             wrap_nx;
    logic             step_s, step_d;
    logic [1:0]       sel_q;
    logic             tick, step_edge, sel_chg, advance;

    // Character codes 0..F are hex digits; BLANK is an unlit digit.
    function automatic logic [4:0] char_code(input logic [1:0] s, input logic [2:0] idx);
        logic [4:0] c;
        c = BLANK;
        case (s)
            2'd0: c = {2'b00, idx};
            2'd1: c = {2'b01, idx};
            2'd2: begin
                case (idx)
                    3'd0: c = 5'hD;
                    3'd1: c = 5'hE;
                    3'd2: c = 5'hA;
                    3'd3: c = 5'hD;
                    3'd4: c = 5'hB;
                    3'd5: c = 5'hE;
                    3'd6: c = 5'hE;
                    default: c = 5'hF;
                endcase
            end
            default: begin
                case (idx)
                    3'd0: c = 5'hC;
                    3'd1: c = 5'hA;
                    3'd2: c = 5'hF;
                    3'd3: c = 5'hE;
                    default: c = BLANK;
                endcase
            end
        endcase
        return c;
    endfunction

    function automatic logic [7:0] glyph(input logic [4:0] c);
        logic [7:0] g;
        g = 8'hFF;
        case (c)
            5'h0: g = 8'hC0;
            5'h1: g = 8'hF9;
            5'h2: g = 8'hA4;
            5'h3: g = 8'hB0;
            5'h4: g = 8'h99;
            5'h5: g = 8'h92;
            5'h6: g = 8'h82;
            5'h7: g = 8'hF8;
            5'h8: g = 8'h80;
            5'h9: g = 8'h90;
            5'hA: g = 8'h88;
            5'hB: g = 8'h83;
            5'hC: g = 8'hC6;
            5'hD: g = 8'hA1;
            5'hE: g = 8'h86;
            5'hF: g = 8'h8E;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    always_comb begin
        tick      = (cnt == CNT_LAST);
        step_edge = step_s & ~step_d;
        sel_chg   = (sel != sel_q);
        advance   = pause ? step_edge : tick;
        cnt_nx    = tick ? '0 : cnt + 1'b1;
        pos_nx    = pos;
        wrap_nx   = 1'b0;
        if (sel_chg) begin
            cnt_nx = '0;
            pos_nx = 3'd0;
        end else if (advance) begin
            if (dir) begin
                pos_nx  = pos - 3'd1;
                wrap_nx = (pos == 3'd0);
            end else begin
                pos_nx  = pos + 3'd1;
                wrap_nx = (pos == 3'd7);
            end
        end
    end

    // Digits are computed from the next position so they always match pos.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            pos    <= 3'd0;
            wrap   <= 1'b0;
            digit3 <= 8'hFF;
            digit2 <= 8'hFF;
            digit1 <= 8'hFF;
            digit0 <= 8'hFF;
            step_s <= step;
            step_d <= step;
            sel_q  <= sel;
        end else begin
            cnt    <= cnt_nx;
            pos    <= pos_nx;
            wrap   <= wrap_nx;
            digit3 <= glyph(char_code(sel, pos_nx));
            digit2 <= glyph(char_code(sel, pos_nx + 3'd1));
            digit1 <= glyph(char_code(sel, pos_nx + 3'd2));
            digit0 <= glyph(char_code(sel, pos_nx + 3'd3));
            step_s <= step;
            step_d <= step_s;
            sel_q  <= sel;
        end
    end

endmodule

// File: tb/tb_pattern_scroller.sv
// Directed bench for pattern_scroller with TICK_DIV=4: scrolling, wrap,
// direction, sel change, pause/step and reset behaviour.
module tb_pattern_scroller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       dir, pause, step;
    logic [7:0] digit3, digit2, digit1, digit0;
    logic [2:0] pos;
    logic       wrap;

    int errors = 0;
    int checks = 0;
    int k = 0;

    localparam logic [7:0] MSG0 [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    pattern_scroller #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .dir(dir), .pause(pause), .step(step),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .pos(pos), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        k++;
    endtask

    function automatic logic [31:0] win0(input int p);
        return {MSG0[p % 8], MSG0[(p + 1) % 8], MSG0[(p + 2) % 8], MSG0[(p + 3) % 8]};
    endfunction

    logic [31:0] digs;
    assign digs = {digit3, digit2, digit1, digit0};

    initial begin
        int ep;
        logic ew;
        rst = 1'b1; sel = 2'd0; dir = 1'b0; pause = 1'b0; step = 1'b0;
        next(); next();
        chk("rst_digits", digs, 32'hFFFF_FFFF);
        chk("rst_pos", {29'd0, pos}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);

        // Phase A: free-running left scroll over sel=0, then one step right.
        rst = 1'b0; k = 0;
        ep = 0;
        for (int i = 1; i <= 37; i++) begin
            next();
            ew = 1'b0;
            if (k % 4 == 0) begin
                if (k <= 32) begin
                    ew = (ep == 7);
                    ep = (ep + 1) % 8;
                end else begin
                    ew = (ep == 0);
                    ep = (ep + 7) % 8;
                end
            end
            chk("a_pos", {29'd0, pos}, ep);
            chk("a_wrap", {31'd0, wrap}, {31'd0, ew});
            chk("a_digits", digs, win0(ep));
            if (k == 1)  chk("first_win", digs, 32'hC0F9_A4B0);
            if (k == 3)  chk("pre_tick_pos", {29'd0, pos}, 32'd0);
            if (k == 4)  chk("tick1_win", digs, 32'hF9A4_B099);
            if (k == 32) begin
                chk("wrap_7_0", {31'd0, wrap}, 32'd1);
                dir = 1'b1;
            end
            if (k == 36) begin
                chk("right_pos", {29'd0, pos}, 32'd7);
                chk("right_wrap", {31'd0, wrap}, 32'd1);
                chk("right_win", digs, 32'hF8C0_F9A4);
            end
        end

        // Phase B: sel=3 window, sel change on a tick, pause/step, reset.
        rst = 1'b1; sel = 2'd3; dir = 1'b0; pause = 1'b0; step = 1'b0;
        next(); next();
        rst = 1'b0; k = 0;
        while (k < 8) next();
        chk("sel3_pos2", {29'd0, pos}, 32'd2);
        chk("sel3_win", digs, 32'h8E86_FFFF);
        while (k < 11) next();
        sel = 2'd1;
        next();
        chk("selchg_pos", {29'd0, pos}, 32'd0);
        chk("selchg_wrap", {31'd0, wrap}, 32'd0);
        chk("selchg_win", digs, 32'h8090_8883);
        while (k < 15) next();
        chk("selchg_hold", {29'd0, pos}, 32'd0);
        next();
        chk("selchg_tick", {29'd0, pos}, 32'd1);
        chk("sel1_win1", digs, 32'h9088_83C6);

        pause = 1'b1;
        while (k < 36) begin
            next();
            chk("paused_pos", {29'd0, pos}, 32'd1);
        end
        step = 1'b1;
        next();
        chk("step_lat1", {29'd0, pos}, 32'd1);
        next();
        chk("step_adv", {29'd0, pos}, 32'd2);
        next();
        step = 1'b0;
        chk("step_once", {29'd0, pos}, 32'd2);
        while (k < 42) begin
            next();
            chk("step_hold", {29'd0, pos}, 32'd2);
        end
        pause = 1'b0;
        next(); next();
        chk("resume_tick", {29'd0, pos}, 32'd3);
        step = 1'b1;
        next(); next();
        step = 1'b0;
        chk("step_unpaused", {29'd0, pos}, 32'd3);
        next();
        chk("step_unpaused2", {29'd0, pos}, 32'd3);
        next();
        chk("tick_after", {29'd0, pos}, 32'd4);
        while (k < 54) next();
        step = 1'b1;
        next();
        chk("pre_rst_pos", {29'd0, pos}, 32'd5);
        rst = 1'b1; pause = 1'b1; sel = 2'd0;
        next();
        chk("midrst_digits", digs, 32'hFFFF_FFFF);
        chk("midrst_pos", {29'd0, pos}, 32'd0);
        chk("midrst_wrap", {31'd0, wrap}, 32'd0);

        // Step held high across reset release must not register as an edge.
        rst = 1'b0;
        next();
        chk("post_rst_win", digs, 32'hC0F9_A4B0);
        for (int i = 0; i < 6; i++) begin
            next();
            chk("no_false_step", {29'd0, pos}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout k=%0d: got running expected finished", k);
        $fatal(1, "timeout");
    end

endmodule
